// File: rtl/toy_pkg.sv
// Shared TOY machine types: word/address vectors, panel command and controller state encodings.
package toy_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {OP_LOAD, OP_LOOK, OP_STEP} panel_op_e;
  typedef enum logic [1:0] {IDLE, REQ, RDWAIT} panel_state_e;

endpackage

// File: rtl/panel_mem_ctrl_if.sv
// Main memory read/write port: single request with val/rdy handshake, read data one cycle after acceptance.
interface mem_rwport #(
  parameter int ADDR_W = toy_pkg::ADDR_W,
  parameter int DATA_W = toy_pkg::DATA_W
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wen;
  logic              val;
  logic [DATA_W-1:0] rdata;
  logic              rdy;

  modport master (output addr, wdata, wen, val, input rdata, rdy);
  modport slave  (input addr, wdata, wen, val, output rdata, rdy);
endinterface

// File: rtl/panel_mem_ctrl.sv
// Front-panel memory controller: turns LOAD/LOOK/STEP pulses into single memory transactions
// and holds the address/data shown on the panel lamps.
module panel_mem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_rwport.master         mem_intf,
  input  logic [ADDR_W-1:0] sw_addr_i,
  input  logic [DATA_W-1:0] sw_data_i,
  input  logic              load_i,
  input  logic              look_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] disp_addr_o,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              busy_o,
  output logic              overrun_o
);
  import toy_pkg::*;

  panel_state_e      state_q, state_d;
  panel_op_e         op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d, disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, disp_data_q, disp_data_d;
  logic              wen_q, wen_d, val_q, val_d, busy_q, busy_d, overrun_q, overrun_d;
  logic              any_pulse, drop_pulse;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = wen_q;
    disp_addr_d = disp_addr_q;
    disp_data_d = disp_data_q;
    overrun_d   = overrun_q;
    any_pulse   = load_i | look_i | step_i;
    drop_pulse  = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_pulse) begin
          state_d = REQ;
          if (load_i) begin
            op_d       = OP_LOAD;
            addr_d     = sw_addr_i;
            wdata_d    = sw_data_i;
            wen_d      = 1'b1;
            drop_pulse = look_i | step_i;
          end else if (look_i) begin
            op_d       = OP_LOOK;
            addr_d     = sw_addr_i;
            wen_d      = 1'b0;
            drop_pulse = step_i;
          end else begin
            op_d       = OP_STEP;
            addr_d     = disp_addr_q + 1'b1;
            wen_d      = 1'b0;
          end
          // Accepting a command clears the sticky flag unless this edge itself drops a pulse.
          overrun_d = drop_pulse;
        end
      end
      REQ: begin
        overrun_d = overrun_q | any_pulse;
        if (mem_intf.rdy) begin
          if (op_q == OP_LOAD) begin
            disp_addr_d = addr_q;
            disp_data_d = wdata_q;
            state_d     = IDLE;
          end else begin
            state_d     = RDWAIT;
          end
        end
      end
      RDWAIT: begin
        overrun_d   = overrun_q | any_pulse;
        disp_addr_d = addr_q;
        disp_data_d = mem_intf.rdata;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    val_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      op_q        <= OP_LOAD;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      val_q       <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      disp_addr_q <= '0;
      disp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      val_q       <= val_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      disp_addr_q <= disp_addr_d;
      disp_data_q <= disp_data_d;
    end
  end

  assign mem_intf.addr  = addr_q;
  assign mem_intf.wdata = wdata_q;
  assign mem_intf.wen   = wen_q;
  assign mem_intf.val   = val_q;
  assign disp_addr_o    = disp_addr_q;
  assign disp_data_o    = disp_data_q;
  assign busy_o         = busy_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_panel_mem_ctrl.sv
// Bench for panel_mem_ctrl: transaction-level reference model checked every cycle, plus literal checks.
module tb_panel_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sw_addr;
  logic [15:0] sw_data;
  logic        load, look, step, rdy;
  logic [7:0]  disp_addr;
  logic [15:0] disp_data;
  logic        busy, overrun;

  int checks = 0;
  int failures = 0;

  mem_rwport #(.ADDR_W(8), .DATA_W(16)) bus ();

  panel_mem_ctrl #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mem_intf    (bus.master),
    .sw_addr_i   (sw_addr),
    .sw_data_i   (sw_data),
    .load_i      (load),
    .look_i      (look),
    .step_i      (step),
    .disp_addr_o (disp_addr),
    .disp_data_o (disp_data),
    .busy_o      (busy),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  // Simple main memory: registered read data, writes on accepted requests.
  logic [15:0] sim_mem [256];
  logic [15:0] rdata_q = 16'h0;
  assign bus.rdata = rdata_q;
  assign bus.rdy   = rdy;
  always @(posedge clk) begin
    if (bus.val && bus.rdy) begin
      if (bus.wen) sim_mem[bus.addr] <= bus.wdata;
      else         rdata_q <= sim_mem[bus.addr];
    end
  end

  // Reference model: a transaction either waits (0), is being offered (1) or returns read data (2).
  logic [15:0] m_mem [256];
  int          m_phase = 0;
  logic        m_write = 1'b0;
  logic [7:0]  m_addr = 8'h0, m_disp_addr = 8'h0;
  logic [15:0] m_wdata = 16'h0, m_disp_data = 16'h0, m_rd = 16'h0;
  logic        m_overrun = 1'b0;

  always @(posedge clk) begin
    int pulses;
    pulses = int'(load) + int'(look) + int'(step);
    if (!rst_n) begin
      m_phase = 0; m_write = 1'b0; m_addr = 8'h0; m_wdata = 16'h0;
      m_disp_addr = 8'h0; m_disp_data = 16'h0; m_overrun = 1'b0;
    end else if (m_phase == 0) begin
      if (pulses > 0) begin
        m_overrun = (pulses > 1);
        m_write   = load;
        if (load) begin m_addr = sw_addr; m_wdata = sw_data; end
        else if (look) m_addr = sw_addr;
        else m_addr = m_disp_addr + 8'd1;
        m_phase = 1;
      end
    end else begin
      if (pulses > 0) m_overrun = 1'b1;
      if (m_phase == 2) begin
        m_disp_addr = m_addr; m_disp_data = m_rd; m_phase = 0;
      end else if (rdy) begin
        if (m_write) begin
          m_mem[m_addr] = m_wdata;
          m_disp_addr = m_addr; m_disp_data = m_wdata; m_phase = 0;
        end else begin
          m_rd = m_mem[m_addr]; m_phase = 2;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
    chk("val", {31'b0, bus.val}, {31'b0, m_phase == 1});
    chk("overrun", {31'b0, overrun}, {31'b0, m_overrun});
    chk("disp_addr", {24'b0, disp_addr}, {24'b0, m_disp_addr});
    chk("disp_data", {16'b0, disp_data}, {16'b0, m_disp_data});
    if (m_phase == 1) begin
      chk("req_addr", {24'b0, bus.addr}, {24'b0, m_addr});
      chk("req_wen", {31'b0, bus.wen}, {31'b0, m_write});
      if (m_write) chk("req_wdata", {16'b0, bus.wdata}, {16'b0, m_wdata});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic l, input logic k, input logic s,
                       input logic [7:0] a, input logic [15:0] d);
    sw_addr = a; sw_data = d; load = l; look = k; step = s;
    tick();
    load = 1'b0; look = 1'b0; step = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      sim_mem[i] = 16'(i * 7 + 3);
      m_mem[i]   = 16'(i * 7 + 3);
    end
    rst_n = 1'b0; rdy = 1'b1; load = 1'b0; look = 1'b0; step = 1'b0;
    sw_addr = 8'h0; sw_data = 16'h0;
    repeat (3) tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_val", {31'b0, bus.val}, 32'd0);
    chk("rst_disp", {8'b0, disp_addr, disp_data}, 32'd0);
    chk("rst_req", {8'b0, bus.addr, bus.wdata}, 32'd0);
    rst_n = 1'b1;
    tick();

    // LOAD 0x10 <= 0xBEEF
    pulse(1, 0, 0, 8'h10, 16'hBEEF);
    chk("load_val_wen", {30'b0, bus.val, bus.wen}, 32'd3);
    chk("load_addr", {24'b0, bus.addr}, 32'h10);
    tick();
    chk("load_disp", {8'b0, disp_addr, disp_data}, 32'h0010BEEF);
    chk("load_busy1", {31'b0, busy}, 32'd0);

    // LOOK 0x10
    pulse(0, 1, 0, 8'h10, 16'h0);
    chk("look_wen", {30'b0, bus.val, bus.wen}, 32'd2);
    tick();
    chk("look_rdwait", {30'b0, bus.val, busy}, 32'd1);
    tick();
    chk("look_data", {16'b0, disp_data}, 32'hBEEF);

    // STEP wraps 0xFF -> 0x00
    pulse(1, 0, 0, 8'hFF, 16'h1234); tick();
    pulse(1, 0, 0, 8'h00, 16'h0001); tick();
    pulse(0, 1, 0, 8'hFF, 16'h0); tick(); tick();
    chk("pre_step", {8'b0, disp_addr, disp_data}, 32'h00FF1234);
    pulse(0, 0, 1, 8'h55, 16'h0);
    chk("step_addr", {24'b0, bus.addr}, 32'h0);
    tick(); tick();
    chk("step_disp", {8'b0, disp_addr, disp_data}, 32'h00000001);

    // Overrun: simultaneous pulses, then a pulse during RDWAIT, then a clean LOOK
    pulse(1, 1, 0, 8'h20, 16'hCAFE);
    chk("ovr_set", {31'b0, overrun}, 32'd1);
    tick();
    chk("ovr_load", {16'b0, disp_data}, 32'hCAFE);
    pulse(0, 1, 1, 8'h20, 16'h0);
    tick();
    pulse(0, 1, 0, 8'h20, 16'h0);
    chk("ovr_hold", {31'b0, overrun}, 32'd1);
    chk("ovr_busy", {31'b0, busy}, 32'd0);
    pulse(0, 1, 0, 8'h20, 16'h0);
    chk("ovr_clear", {31'b0, overrun}, 32'd0);
    tick(); tick();

    // Three rdy-low cycles stretch a write by exactly three cycles
    rdy = 1'b0;
    pulse(1, 0, 0, 8'h30, 16'h5A5A);
    tick(); tick(); tick();
    chk("stall_busy", {31'b0, busy}, 32'd1);
    chk("stall_req", {7'b0, bus.wen, bus.addr, bus.wdata}, 32'h01305A5A);
    chk("stall_disp", {16'b0, disp_data}, 32'hCAFE);
    rdy = 1'b1;
    tick();
    chk("stall_done", {8'b0, disp_addr, disp_data}, 32'h00305A5A);

    // Reset during RDWAIT
    pulse(0, 1, 0, 8'h10, 16'h0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst", {6'b0, bus.val, busy, disp_addr, disp_data}, 32'd0);
    rst_n = 1'b1;
    tick();
    pulse(0, 1, 0, 8'h30, 16'h0); tick(); tick();
    chk("after_rst_read", {16'b0, disp_data}, 32'h5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
